// File: rtl/axis_gap_pkg.sv
// Shared types and constants for the TX egress frame-gap stage.
package axis_gap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP,
    GAP
  } gap_state_e;

  localparam int GAP_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 16;

  localparam logic [15:0] STAT_TRUNC_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-register AXI-Stream output stage (output + temp register) with a registered upstream ready.
// in_ready_early_o is the value in_ready_o takes on the next cycle, for callers that gate their own ready.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_early_o,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             in_ready_q;
  logic             out_valid_q, out_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [WIDTH-1:0] out_data_q, temp_data_q;
  logic             load_out_in, load_out_temp, load_temp_in;

  // Ready next cycle unless the temp slot is full or would fill this cycle.
  assign in_ready_early_o = out_ready_i || (!temp_valid_q && (!out_valid_q || !in_valid_i));

  always_comb begin
    out_valid_d   = out_valid_q;
    temp_valid_d  = temp_valid_q;
    load_out_in   = 1'b0;
    load_out_temp = 1'b0;
    load_temp_in  = 1'b0;
    if (in_ready_q) begin
      if (out_ready_i || !out_valid_q) begin
        out_valid_d = in_valid_i;
        load_out_in = 1'b1;
      end else begin
        temp_valid_d = in_valid_i;
        load_temp_in = 1'b1;
      end
    end else if (out_ready_i) begin
      out_valid_d   = temp_valid_q;
      temp_valid_d  = 1'b0;
      load_out_temp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      temp_valid_q <= 1'b0;
      out_data_q   <= '0;
      temp_data_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_early_o;
      out_valid_q  <= out_valid_d;
      temp_valid_q <= temp_valid_d;
      if (load_out_in) begin
        out_data_q <= in_data_i;
      end else if (load_out_temp) begin
        out_data_q <= temp_data_q;
      end
      if (load_temp_in) begin
        temp_data_q <= in_data_i;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/axis_frame_gap.sv
// Egress stage after the rate limiter: enforces a minimum s-side idle gap after each frame
// and truncates over-length frames, marking them bad on tuser[0].
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// PASS  | forwarding beats of the current frame
// DROP  | frame was truncated; swallowing beats up to its tlast
// GAP   | holding s_axis_tready low for the configured idle gap
module axis_frame_gap
  import axis_gap_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int GAP_WIDTH   = GAP_WIDTH_DEF,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_trunc
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  gap_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0] max_len_q, max_len_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]          stat_trunc_q, stat_trunc_d;
  logic [31:0]          stat_frames_q;
  logic                 s_ready_q, s_ready_early;

  logic                  s_accept, fwd_valid, force_bad, frame_end;
  logic [LEN_WIDTH-1:0]  lim, idx;
  logic [USER_WIDTH-1:0] user_fwd;
  logic [KEEP_WIDTH-1:0] keep_fwd;
  logic [ID_WIDTH-1:0]   id_fwd;
  logic [DEST_WIDTH-1:0] dest_fwd;
  logic [PW-1:0]         fwd_data, out_data;
  logic                  out_ready_early, skid_ready;

  assign s_accept = s_axis_tvalid && s_ready_q;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    max_len_d    = max_len_q;
    gap_cnt_d    = gap_cnt_q;
    stat_trunc_d = stat_trunc_q;
    fwd_valid    = 1'b0;
    force_bad    = 1'b0;
    frame_end    = 1'b0;
    // The first beat of a frame sees the live limit; later beats use the latched one.
    lim = max_len_q;
    idx = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + LEN_WIDTH'(1);
    if (state_q == IDLE) begin
      lim = cfg_max_len;
      idx = LEN_WIDTH'(1);
    end
    case (state_q)
      IDLE, PASS: begin
        if (s_accept) begin
          fwd_valid  = 1'b1;
          word_cnt_d = idx;
          max_len_d  = lim;
          if (s_axis_tlast) begin
            frame_end = 1'b1;
          end else if ((lim != '0) && (idx == lim)) begin
            force_bad = 1'b1;
            state_d   = DROP;
            if (stat_trunc_q != STAT_TRUNC_MAX) begin
              stat_trunc_d = stat_trunc_q + 16'd1;
            end
          end else begin
            state_d = PASS;
          end
        end
      end
      DROP: begin
        if (s_accept && s_axis_tlast) begin
          frame_end = 1'b1;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      if (cfg_gap != '0) begin
        state_d   = GAP;
        gap_cnt_d = cfg_gap;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Keyed on the next state so the registered ready drops on the cycle right after tlast.
  assign s_ready_early = (state_d == DROP) || (out_ready_early && (state_d != GAP));

  always_comb begin
    user_fwd = USER_ENABLE ? s_axis_tuser : '0;
    if (USER_ENABLE && force_bad) begin
      user_fwd[0] = 1'b1;
    end
  end

  assign keep_fwd = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign id_fwd   = ID_ENABLE ? s_axis_tid : '0;
  assign dest_fwd = DEST_ENABLE ? s_axis_tdest : '0;
  assign fwd_data = {s_axis_tlast | force_bad, user_fwd, dest_fwd, id_fwd, keep_fwd, s_axis_tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      max_len_q     <= '0;
      gap_cnt_q     <= '0;
      stat_trunc_q  <= '0;
      stat_frames_q <= '0;
      s_ready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      max_len_q    <= max_len_d;
      gap_cnt_q    <= gap_cnt_d;
      stat_trunc_q <= stat_trunc_d;
      s_ready_q    <= s_ready_early;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        stat_frames_q <= stat_frames_q + 32'd1;
      end
    end
  end

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_out (
    .clk              (clk),
    .rst              (rst),
    .in_valid_i       (fwd_valid && skid_ready),
    .in_data_i        (fwd_data),
    .in_ready_early_o (out_ready_early),
    .in_ready_o       (skid_ready),
    .out_valid_o      (m_axis_tvalid),
    .out_data_o       (out_data),
    .out_ready_i      (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tkeep, m_axis_tdata} = out_data;

  assign s_axis_tready = s_ready_q;
  assign stat_frames   = stat_frames_q;
  assign stat_trunc    = stat_trunc_q;

endmodule

// File: tb/tb_axis_frame_gap.sv
// Self-checking bench for axis_frame_gap: directed scenarios plus a randomized run
// against a per-frame reference model of gap and truncation behaviour.
module tb_axis_frame_gap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic [0:0]  s_tkeep = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  s_tid = '0;
  logic [7:0]  s_tdest = '0;
  logic [0:0]  s_tuser = '0;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [7:0]  m_tid;
  logic [7:0]  m_tdest;
  logic [0:0]  m_tuser;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] cfg_max_len = '0;
  logic [31:0] stat_frames;
  logic [15:0] stat_trunc;

  axis_frame_gap dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .cfg_gap(cfg_gap), .cfg_max_len(cfg_max_len),
    .stat_frames(stat_frames), .stat_trunc(stat_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int gap_runs[$];
  int stab_err = 0;
  int first_mv_cyc = -1;
  int first_acc_cyc = -1;
  int exp_frames = 0;
  int exp_trunc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observer: collects m-side transfers, stall stability and s-side ready-low runs after each tlast.
  initial begin
    bit prev_stall;
    logic [9:0] prev_m;
    bit meas;
    int run;
    prev_stall = 1'b0;
    prev_m = '0;
    meas = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        meas = 1'b0;
      end else begin
        if (prev_stall && (!m_tvalid || ({m_tuser[0], m_tlast, m_tdata} !== prev_m))) stab_err++;
        prev_stall = m_tvalid && !m_tready;
        prev_m = {m_tuser[0], m_tlast, m_tdata};
        if (m_tvalid && first_mv_cyc < 0) first_mv_cyc = cyc;
        if (m_tvalid && m_tready) got_q.push_back({m_tuser[0], m_tlast, m_tdata});
        if (meas) begin
          if (!s_tready) run++;
          else begin
            gap_runs.push_back(run);
            meas = 1'b0;
          end
        end
        if (s_tvalid && s_tready && s_tlast) begin
          meas = 1'b1;
          run = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    gap_runs.delete();
    stab_err = 0;
    exp_frames = 0;
    exp_trunc = 0;
    first_mv_cyc = -1;
    first_acc_cyc = -1;
  endtask

  // Reference: a frame of L beats under limit M (0 = unlimited) yields min(L, M) beats;
  // when cut short, the last emitted beat carries tlast and tuser=1.
  task automatic model_frame(input logic [7:0] d[$], input logic u[$], input int maxlen);
    int n;
    bit tr;
    tr = (maxlen != 0) && (d.size() > maxlen);
    n = tr ? maxlen : d.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back({(tr && i == n - 1) ? 1'b1 : u[i], 1'(i == n - 1), d[i]});
    exp_frames++;
    if (tr) exp_trunc++;
  endtask

  task automatic send_frame(input logic [7:0] d[$], input logic u[$], input bit with_last, input bit gaps);
    int n;
    for (int i = 0; i < d.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata = d[i];
      s_tuser = u[i];
      s_tlast = with_last && (i == d.size() - 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_tready && n < 2000);
      if (!s_tready) begin
        total++;
        $display("FAIL send_timeout: s_axis_tready=%b after %0d cycles on beat %0d, required 1", s_tready, n, i);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_drain(input int tail);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (s_tready !== 1'b0) $display("FAIL reset_s_tready: got %b required 0", s_tready); else passed++;
    total++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); else passed++;
    total++; if (stat_frames !== 32'd0) $display("FAIL reset_stat_frames: got %0d required 0", stat_frames); else passed++;
    total++; if (stat_trunc !== 16'd0) $display("FAIL reset_stat_trunc: got %0d required 0", stat_trunc); else passed++;
    @(posedge clk);
    #1;
    total++; if (s_tready !== 1'b1) $display("FAIL reset_ready_rise: got %b required 1", s_tready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd0;
    cfg_max_len = 16'd0;
    for (int f = 0; f < 2; f++) begin
      d.delete();
      u.delete();
      for (int i = 0; i < 4; i++) begin
        d.push_back(8'(8'h10 * (f + 1) + i));
        u.push_back(1'b0);
      end
      model_frame(d, u, 0);
      send_frame(d, u, 1'b1, 1'b0);
    end
    wait_drain(4);
    total++; if (got_q.size() !== 8) $display("FAIL b2b_count: got %0d beats required 8", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (first_mv_cyc !== first_acc_cyc) $display("FAIL b2b_latency: m_tvalid after edge %0d, required edge %0d", first_mv_cyc, first_acc_cyc); else passed++;
    total++; if (stat_frames !== 32'd2) $display("FAIL b2b_stat_frames: got %0d required 2", stat_frames); else passed++;
    total++; if (m_tkeep !== 1'b1) $display("FAIL b2b_tkeep: got %b required 1", m_tkeep); else passed++;
  endtask

  task automatic test_gap();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd5;
    cfg_max_len = 16'd0;
    for (int f = 0; f < 2; f++) begin
      d.delete();
      u.delete();
      for (int i = 0; i < 3; i++) begin
        d.push_back(8'(8'h30 + 8'h10 * f + i));
        u.push_back(1'b0);
      end
      model_frame(d, u, 0);
      send_frame(d, u, 1'b1, 1'b0);
    end
    wait_drain(10);
    total++; if (gap_runs.size() !== 2) $display("FAIL gap_run_count: got %0d required 2", gap_runs.size()); else passed++;
    for (int i = 0; i < gap_runs.size(); i++) begin
      total++; if (gap_runs[i] !== 5) $display("FAIL gap_len%0d: ready low %0d cycles required 5", i, gap_runs[i]); else passed++;
    end
    total++; if (got_q.size() !== 6) $display("FAIL gap_count: got %0d beats required 6", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL gap_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_trunc();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd0;
    cfg_max_len = 16'd4;
    for (int i = 0; i < 10; i++) begin
      d.push_back(8'(i));
      u.push_back(1'b0);
    end
    model_frame(d, u, 4);
    send_frame(d, u, 1'b1, 1'b0);
    d = '{8'hA0, 8'hA1};
    u = '{1'b0, 1'b0};
    model_frame(d, u, 4);
    send_frame(d, u, 1'b1, 1'b0);
    wait_drain(4);
    total++; if (got_q.size() !== 6) $display("FAIL trunc_count: got %0d beats required 6", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL trunc_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (stat_trunc !== 16'd1) $display("FAIL trunc_stat_trunc: got %0d required 1", stat_trunc); else passed++;
    total++; if (stat_frames !== 32'd2) $display("FAIL trunc_stat_frames: got %0d required 2", stat_frames); else passed++;
  endtask

  task automatic test_exact_len();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd0;
    cfg_max_len = 16'd4;
    d = '{8'h70, 8'h71, 8'h72, 8'h73};
    u = '{1'b0, 1'b0, 1'b0, 1'b0};
    model_frame(d, u, 4);
    send_frame(d, u, 1'b1, 1'b0);
    wait_drain(4);
    total++; if (got_q.size() !== 4) $display("FAIL exact_count: got %0d beats required 4", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL exact_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (stat_trunc !== 16'd0) $display("FAIL exact_stat_trunc: got %0d required 0", stat_trunc); else passed++;
  endtask

  task automatic test_maxlen_one();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd0;
    cfg_max_len = 16'd1;
    d = '{8'h51, 8'h52, 8'h53};
    u = '{1'b0, 1'b0, 1'b0};
    model_frame(d, u, 1);
    send_frame(d, u, 1'b1, 1'b0);
    d = '{8'h60};
    u = '{1'b0};
    model_frame(d, u, 1);
    send_frame(d, u, 1'b1, 1'b0);
    wait_drain(4);
    total++; if (got_q.size() !== 2) $display("FAIL len1_count: got %0d beats required 2", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL len1_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (stat_trunc !== 16'd1) $display("FAIL len1_stat_trunc: got %0d required 1", stat_trunc); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    logic u[$];
    int len, ml, short_gaps;
    apply_reset();
    rand_ready = 1'b1;
    cfg_gap = 8'd3;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 8);
      ml = $urandom_range(0, 6);
      cfg_max_len = 16'(ml);
      d.delete();
      u.delete();
      for (int i = 0; i < len; i++) begin
        d.push_back(8'($urandom_range(0, 255)));
        u.push_back(1'($urandom_range(0, 1)));
      end
      model_frame(d, u, ml);
      send_frame(d, u, 1'b1, 1'b1);
    end
    wait_drain(20);
    rand_ready = 1'b0;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d beats required %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (stab_err !== 0) $display("FAIL rand_stall_stable: %0d unstable stall cycles, required 0", stab_err); else passed++;
    total++; if (gap_runs.size() !== 20) $display("FAIL rand_gap_count: got %0d required 20", gap_runs.size()); else passed++;
    short_gaps = 0;
    foreach (gap_runs[i]) if (gap_runs[i] < 3) short_gaps++;
    total++; if (short_gaps !== 0) $display("FAIL rand_gap_min: %0d gaps below 3 cycles, required 0", short_gaps); else passed++;
    total++; if (stat_frames !== 32'(exp_frames)) $display("FAIL rand_stat_frames: got %0d required %0d", stat_frames, exp_frames); else passed++;
    total++; if (stat_trunc !== 16'(exp_trunc)) $display("FAIL rand_stat_trunc: got %0d required %0d", stat_trunc, exp_trunc); else passed++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] d[$];
    logic u[$];
    apply_reset();
    cfg_gap = 8'd0;
    cfg_max_len = 16'd0;
    d = '{8'h81, 8'h82, 8'h83};
    u = '{1'b0, 1'b0, 1'b0};
    send_frame(d, u, 1'b1, 1'b0);
    d = '{8'h90, 8'h91};
    u = '{1'b0, 1'b0};
    send_frame(d, u, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (stat_frames !== 32'd1) $display("FAIL mrst_pre_frames: got %0d required 1", stat_frames); else passed++;
    s_tvalid = 1'b1;
    s_tdata = 8'h92;
    s_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    total++; if (m_tvalid !== 1'b0) $display("FAIL mrst_m_tvalid: got %b required 0", m_tvalid); else passed++;
    total++; if (s_tready !== 1'b0) $display("FAIL mrst_s_tready: got %b required 0", s_tready); else passed++;
    total++; if (stat_frames !== 32'd0) $display("FAIL mrst_stat_frames: got %0d required 0", stat_frames); else passed++;
    total++; if (stat_trunc !== 16'd0) $display("FAIL mrst_stat_trunc: got %0d required 0", stat_trunc); else passed++;
    got_q.delete();
    exp_q.delete();
    d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    u = '{1'b0, 1'b0, 1'b0, 1'b0};
    model_frame(d, u, 0);
    send_frame(d, u, 1'b1, 1'b0);
    wait_drain(4);
    total++; if (got_q.size() !== 4) $display("FAIL mrst_count: got %0d beats required 4", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL mrst_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (stat_frames !== 32'd1) $display("FAIL mrst_post_frames: got %0d required 1", stat_frames); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_trunc();
    test_exact_len();
    test_maxlen_one();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_frame_gap.md
Name: axis_frame_gap

Overview:
- AXI4-Stream stage placed directly downstream of the rate limiter in the TX egress path.
- Enforces a configurable minimum idle gap, in clock cycles, between frames.
- Truncates frames longer than a configurable maximum word count. Truncated frames are marked bad via tuser[0], and their remainder is discarded.
- Per-frame and truncation statistics are exposed for the CSR block.

Parameters:
- DATA_WIDTH, 8, tdata width in bits
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; if 0, m_axis_tkeep is all ones
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
- ID_ENABLE, 0, propagate tid
- ID_WIDTH, 8, tid width
- DEST_ENABLE, 0, propagate tdest
- DEST_WIDTH, 8, tdest width
- USER_ENABLE, 1, propagate tuser; if 0, m_axis_tuser is 0 (bad marking is lost)
- USER_WIDTH, 1, tuser width (>=1)
- GAP_WIDTH, 8, width of the gap counter and cfg_gap
- LEN_WIDTH, 16, width of the word counter and cfg_max_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per params  input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per params  output stream
- cfg_gap  in  GAP_WIDTH  minimum idle cycles after each frame end; 0 = back-to-back
- cfg_max_len  in  LEN_WIDTH  maximum words per frame; 0 = unlimited
- stat_frames  out  32  frames emitted (m-side tlast transfers); wraps
- stat_trunc  out  16  frames truncated; saturates at 16'hFFFF

Behaviour:
Reset: clk and rst as decided (rst synchronous, active-high). On rst, and in the cycle after it:
- s_axis_tready=0, m_axis_tvalid=0
- stat_frames=0, stat_trunc=0
- state=IDLE, word counter=0, gap counter=0
- Reset mid-frame drops any partial frame. No tlast is emitted for it.

Output datapath:
- Two-register skid buffer: output register plus temp register.
- s_axis_tready is fully registered.
- Latency is 1 cycle from s-side accept to m_axis_tvalid when the output side is not stalled.
- m_axis_* is stable while tvalid=1 and tready=0.

Internal s_ready, one cycle early, = out_ready_early AND (state != GAP).
- out_ready_early uses the same rule as the family output stage.
- In DROP state, s_ready = 1 regardless of output backpressure.

FSM, advancing on s-side accept (s_axis_tvalid && s_axis_tready):
- IDLE
  - On the first beat, latch cfg_max_len into max_len_q and set word counter = 1.
  - Forward the beat.
  - If tlast, or truncation applies, act on the same beat exactly as PASS does.
  - Otherwise go to PASS.
- PASS
  - Forward each beat. Increment the word counter, saturating at all-ones.
  - Beat with tlast=1: go to GAP if cfg_gap != 0, else go to IDLE.
  - Beat with tlast=0, max_len_q != 0 and word index == max_len_q: emit it with tlast forced to 1 and tuser[0] forced to 1. Increment stat_trunc, then go to DROP.
- DROP
  - Accept and discard beats; nothing reaches the output.
  - On the discarded tlast beat, go to GAP if cfg_gap != 0, else go to IDLE.
- GAP
  - On entry, load the gap counter with cfg_gap (sampled on the terminating beat).
  - Decrement every cycle. s_ready stays 0 while in GAP.
  - Leave for IDLE when the counter reaches 1, so that exactly cfg_gap cycles have s_axis_tready=0 after the terminating beat (1-cycle registered-ready slip included in the count).

Gap rules:
- The gap is measured on the s-side.
- Downstream stalls may lengthen the m-side gap but never shorten it below cfg_gap once buffered data drains.

Boundary cases:
- cfg_max_len = 1: every multi-beat frame becomes a 1-beat bad frame.
- Frame length exactly cfg_max_len with tlast on the last beat: passes unmodified and is not counted as truncated.
- cfg changes mid-frame: cfg_max_len takes effect from the next frame. cfg_gap is sampled on the terminating beat.
- stat_frames increments on m_axis_tvalid && m_axis_tready && m_axis_tlast.

Decomposition:
- Package axis_gap_pkg:
  - state enum {IDLE, PASS, DROP, GAP}
  - default GAP_WIDTH and LEN_WIDTH constants
  - STAT_TRUNC_MAX constant
- Sub-module axis_skid_reg: the parameterised two-register output stage with the registered-ready early signal. It is reusable by other stages in the egress path.

Test Plan:
- cfg_gap=0, cfg_max_len=0, two 4-beat frames back-to-back, m_tready=1 -> 8 output beats with unchanged data; first m_tvalid 1 cycle after first accept; stat_frames=2.
- cfg_gap=5, two 3-beat frames -> s_axis_tready low for exactly 5 cycles after the first frame's tlast accept; second frame intact.
- cfg_max_len=4, 10-beat frame 0x00..0x09 followed by a 2-beat frame -> output 0x00..0x03 with tlast and tuser[0]=1 on 0x03; beats 0x04..0x09 consumed and dropped; 2-beat frame passes intact; stat_trunc=1, stat_frames=2.
- cfg_max_len=4, 4-beat frame with tlast on beat 4 -> unmodified, tuser[0]=0, stat_trunc=0.
- Random m_tready (50%), cfg_gap=3, 20 random frames -> scoreboard matches, no beat lost or duplicated, m_* stable under stall, gap invariant holds.
- rst asserted on beat 2 of a 5-beat frame -> next cycle m_tvalid=0, s_tready=0, stats=0; the following frame passes intact.
